// File: rtl/adc_pkg.sv
// Shared state encodings, default geometry and small helpers for the ADC burst reader.
// No logic of its own.
package adc_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CONV = 3'd1,
      S_WAIT = 3'd2,
      S_READ = 3'd3,
      S_ACC  = 3'd4
   } state_t;

   localparam int NBIT_DEF    = 14;
   localparam int NLANE_DEF   = 2;
   localparam int CLKDIV_DEF  = 2;
   localparam int MAXAVG_DEF  = 4;
   localparam int TIMEOUT_DEF = 255;

   // Averaging depth requested by the host, limited to what the accumulators can hold.
   function automatic logic [2:0] clamp_navg(input logic [2:0] n, input int unsigned maxavg);
      if (32'(n) > maxavg) begin
         return 3'(maxavg);
      end
      return n;
   endfunction

endpackage

// File: rtl/adc_burst_reader_if.sv
// Host/converter-facing signal bundle of the burst reader; the reader takes the slave
// side, whoever issues bursts and models the converter pins takes the master side.
interface adc_burst_reader_if import adc_pkg::*; #(
   parameter int NBIT  = NBIT_DEF,
   parameter int NLANE = NLANE_DEF
);

   logic                   start;
   logic [2:0]             navg;
   logic                   busy;
   logic [NLANE-1:0]       dout;
   logic                   cnvst_n;
   logic                   cs_n;
   logic                   sclk;
   logic [NLANE*NBIT-1:0]  data_out;
   logic                   rdy;
   logic                   done;
   logic                   err;
   logic [2:0]             state;

   modport master (
      output start, navg, busy, dout,
      input  cnvst_n, cs_n, sclk, data_out, rdy, done, err, state
   );

   modport slave (
      input  start, navg, busy, dout,
      output cnvst_n, cs_n, sclk, data_out, rdy, done, err, state
   );

endinterface

// File: rtl/adc_lane_acc.sv
// One DOUT lane: MSB-first shift register, wide accumulator and averaged result register.
// The result loads in the same cycle as the final accumulate, so it includes that sample.
module adc_lane_acc import adc_pkg::*; #(
   parameter int NBIT   = NBIT_DEF,
   parameter int MAXAVG = MAXAVG_DEF,
   parameter int SIGNED = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            shift_en,
   input  logic            din,
   input  logic            acc_en,
   input  logic            load_en,
   input  logic [2:0]      nsh,
   output logic [NBIT-1:0] result
);

   localparam int AW = NBIT + MAXAVG;

   logic [NBIT-1:0] sr;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   sample_ext;
   logic [AW-1:0]   sum;
   logic [NBIT-1:0] avg;

   always_comb begin
      sample_ext = (SIGNED != 0) ? {{MAXAVG{sr[NBIT-1]}}, sr} : {{MAXAVG{1'b0}}, sr};
      sum        = acc + sample_ext;
      // Arithmetic shift floors toward minus infinity for negative sums.
      if (SIGNED != 0) begin
         avg = NBIT'($signed(sum) >>> nsh);
      end else begin
         avg = NBIT'(sum >> nsh);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr     <= '0;
         acc    <= '0;
         result <= '0;
      end else begin
         if (shift_en) begin
            sr <= {sr[NBIT-2:0], din};
         end
         if (clr) begin
            acc <= '0;
         end else if (acc_en) begin
            acc <= sum;
         end
         if (load_en) begin
            result <= avg;
         end
      end
   end

endmodule

// File: rtl/adc_burst_reader.sv
// Burst reader for a multi-lane serial ADC: runs 2^navg conversions and outputs per-lane averages.
// Burst latency is per conversion CONV+WAIT (busy driven) + 2*CLKDIV*NBIT read + 1 accumulate cycle.
module adc_burst_reader import adc_pkg::*; #(
   parameter int NBIT    = NBIT_DEF,
   parameter int NLANE   = NLANE_DEF,
   parameter int CLKDIV  = CLKDIV_DEF,
   parameter int MAXAVG  = MAXAVG_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int SIGNED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   adc_burst_reader_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = $clog2(2 * CLKDIV);
   localparam int BW = $clog2(NBIT);

   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLKDIV - 1);
   localparam logic [PW-1:0] PH_HI_LAST = PW'(CLKDIV - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(NBIT - 1);

   state_t          state_q, state_d;
   logic            cnvst_n_q, cnvst_n_d;
   logic            cs_n_q, cs_n_d;
   logic            sclk_q, sclk_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [PW-1:0]   ph_q, ph_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [7:0]      conv_q, conv_d;
   logic [2:0]      navg_q, navg_d;

   logic            clr;
   logic            shift_en;
   logic            acc_en;
   logic            load_en;
   logic            last_conv;
   logic [NLANE*NBIT-1:0] data_all;

   assign last_conv = (conv_q == ((8'd1 << navg_q) - 8'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnvst_n_q <= 1'b1;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         tcnt_q    <= '0;
         ph_q      <= '0;
         bit_q     <= '0;
         conv_q    <= '0;
         navg_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnvst_n_q <= cnvst_n_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         done_q    <= done_d;
         err_q     <= err_d;
         tcnt_q    <= tcnt_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         conv_q    <= conv_d;
         navg_q    <= navg_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnvst_n_d = cnvst_n_q;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      done_d    = 1'b0;
      err_d     = err_q;
      tcnt_d    = tcnt_q;
      ph_d      = ph_q;
      bit_d     = bit_q;
      conv_d    = conv_q;
      navg_d    = navg_q;
      clr       = 1'b0;
      shift_en  = 1'b0;
      acc_en    = 1'b0;
      load_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d   = S_CONV;
               cnvst_n_d = 1'b0;
               navg_d    = clamp_navg(bus.navg, MAXAVG);
               clr       = 1'b1;
               err_d     = 1'b0;
               tcnt_d    = '0;
               conv_d    = '0;
            end
         end

         S_CONV, S_WAIT: begin
            // One timer spans both phases; expiry abandons the burst and keeps old results.
            if (tcnt_q == TO_LAST) begin
               state_d   = S_IDLE;
               err_d     = 1'b1;
               done_d    = 1'b1;
               cnvst_n_d = 1'b1;
               cs_n_d    = 1'b1;
               sclk_d    = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
               if (state_q == S_CONV && bus.busy) begin
                  state_d   = S_WAIT;
                  cnvst_n_d = 1'b1;
               end else if (state_q == S_WAIT && !bus.busy) begin
                  state_d = S_READ;
                  cs_n_d  = 1'b0;
                  sclk_d  = 1'b1;
                  ph_d    = '0;
                  bit_d   = '0;
               end
            end
         end

         S_READ: begin
            if (ph_q == PH_LAST) begin
               ph_d   = '0;
               sclk_d = 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d = S_ACC;
                  cs_n_d  = 1'b1;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               ph_d = ph_q + PW'(1);
               // Lanes capture on the final high cycle, i.e. coincident with the falling SCLK edge.
               if (ph_q == PH_HI_LAST) begin
                  shift_en = 1'b1;
                  sclk_d   = 1'b0;
               end
            end
         end

         S_ACC: begin
            acc_en = 1'b1;
            conv_d = conv_q + 8'd1;
            if (last_conv) begin
               state_d = S_IDLE;
               load_en = 1'b1;
               done_d  = 1'b1;
            end else begin
               state_d   = S_CONV;
               cnvst_n_d = 1'b0;
               tcnt_d    = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   for (genvar l = 0; l < NLANE; l++) begin : g_lane
      adc_lane_acc #(
         .NBIT   (NBIT),
         .MAXAVG (MAXAVG),
         .SIGNED (SIGNED)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr),
         .shift_en (shift_en),
         .din      (bus.dout[l]),
         .acc_en   (acc_en),
         .load_en  (load_en),
         .nsh      (navg_q),
         .result   (data_all[l*NBIT +: NBIT])
      );
   end

   assign bus.cnvst_n  = cnvst_n_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.sclk     = sclk_q;
   assign bus.data_out = data_all;
   assign bus.rdy      = (state_q == S_IDLE);
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.state    = state_q;

endmodule
